// File: rtl/mem_sequencer.sv
// Memory-stage sequencer: turns execute-stage memory ops and interrupts into
// per-cycle strobe/select patterns for the memory stage.
module mem_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [2:0] op_code,
    input  logic       int_req,
    output logic       op_ready,
    output logic       busy,
    output logic       memory_read,
    output logic       memory_write,
    output logic       memory_push,
    output logic       memory_pop,
    output logic [1:0] memory_address_select,
    output logic [1:0] memory_write_src_select,
    output logic       pc_choose_memory,
    output logic       interrupt,
    output logic       restore_flags,
    output logic       int_ack
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 4;

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STD  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_PUSH = OP_W'(3);
    localparam logic [OP_W-1:0] OP_POP  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_CALL = OP_W'(5);
    localparam logic [OP_W-1:0] OP_RET  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_RTI  = OP_W'(7);

    localparam logic [SEL_W-1:0] ADDR_STD = SEL_W'(0);
    localparam logic [SEL_W-1:0] ADDR_LDD = SEL_W'(1);
    localparam logic [SEL_W-1:0] ADDR_SP  = SEL_W'(2);

    localparam logic [SEL_W-1:0] SRC_FLAGS = SEL_W'(0);
    localparam logic [SEL_W-1:0] SRC_PC_HI = SEL_W'(1);
    localparam logic [SEL_W-1:0] SRC_PC_LO = SEL_W'(2);
    localparam logic [SEL_W-1:0] SRC_REG   = SEL_W'(3);

    typedef enum logic [ST_W-1:0] {
        IDLE    = 4'd0,
        ONE     = 4'd1,
        CALL_HI = 4'd2,
        CALL_LO = 4'd3,
        RET_LO  = 4'd4,
        RET_HI  = 4'd5,
        RTI_FLG = 4'd6,
        RTI_LO  = 4'd7,
        RTI_HI  = 4'd8,
        LOAD_PC = 4'd9,
        INT_HI  = 4'd10,
        INT_LO  = 4'd11,
        INT_FLG = 4'd12,
        INT_JMP = 4'd13
    } state_t;

    typedef struct packed {
        logic             rd;
        logic             wr;
        logic             push;
        logic             pop;
        logic [SEL_W-1:0] addr;
        logic [SEL_W-1:0] src;
        logic             pcm;
        logic             intr;
        logic             rflg;
        logic             ack;
    } out_t;

    state_t          state_q, state_d;
    logic [OP_W-1:0] opc_q, opc_d;
    out_t            out_q, out_d;

    // Next state: interrupts win in IDLE; every sequence ends by passing through IDLE.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            IDLE: begin
                if (int_req) begin
                    state_d = INT_HI;
                end else if (op_valid) begin
                    opc_d = op_code;
                    case (op_code)
                        OP_LDD, OP_STD, OP_PUSH, OP_POP: state_d = ONE;
                        OP_CALL: state_d = CALL_HI;
                        OP_RET:  state_d = RET_LO;
                        OP_RTI:  state_d = RTI_FLG;
                        default: state_d = IDLE;
                    endcase
                end
            end
            CALL_HI: state_d = CALL_LO;
            RET_LO:  state_d = RET_HI;
            RET_HI:  state_d = LOAD_PC;
            RTI_FLG: state_d = RTI_LO;
            RTI_LO:  state_d = RTI_HI;
            RTI_HI:  state_d = LOAD_PC;
            INT_HI:  state_d = INT_LO;
            INT_LO:  state_d = INT_FLG;
            INT_FLG: state_d = INT_JMP;
            default: state_d = IDLE;
        endcase
    end

    // Output pattern for the state being entered, so strobes leave a register.
    always_comb begin
        out_d = '0;
        case (state_d)
            ONE: begin
                case (opc_d)
                    OP_LDD: begin
                        out_d.rd   = 1'b1;
                        out_d.addr = ADDR_LDD;
                    end
                    OP_STD: begin
                        out_d.wr   = 1'b1;
                        out_d.addr = ADDR_STD;
                        out_d.src  = SRC_REG;
                    end
                    OP_PUSH: begin
                        out_d.push = 1'b1;
                        out_d.wr   = 1'b1;
                        out_d.addr = ADDR_SP;
                        out_d.src  = SRC_REG;
                    end
                    OP_POP: begin
                        out_d.pop  = 1'b1;
                        out_d.rd   = 1'b1;
                        out_d.addr = ADDR_SP;
                    end
                    default: out_d = '0;
                endcase
            end
            CALL_HI, INT_HI: begin
                out_d.push = 1'b1;
                out_d.wr   = 1'b1;
                out_d.addr = ADDR_SP;
                out_d.src  = SRC_PC_HI;
            end
            CALL_LO, INT_LO: begin
                out_d.push = 1'b1;
                out_d.wr   = 1'b1;
                out_d.addr = ADDR_SP;
                out_d.src  = SRC_PC_LO;
            end
            INT_FLG: begin
                out_d.push = 1'b1;
                out_d.wr   = 1'b1;
                out_d.addr = ADDR_SP;
                out_d.src  = SRC_FLAGS;
            end
            RET_LO, RET_HI, RTI_LO, RTI_HI: begin
                out_d.pop  = 1'b1;
                out_d.rd   = 1'b1;
                out_d.addr = ADDR_SP;
            end
            RTI_FLG: begin
                out_d.pop  = 1'b1;
                out_d.rd   = 1'b1;
                out_d.addr = ADDR_SP;
                out_d.rflg = 1'b1;
            end
            LOAD_PC: out_d.pcm = 1'b1;
            INT_JMP: begin
                out_d.intr = 1'b1;
                out_d.ack  = 1'b1;
            end
            default: out_d = '0;
        endcase
    end

    // State, latched op and registered outputs; reset abandons any sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opc_q   <= OP_NOP;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            out_q   <= out_d;
        end
    end

    assign op_ready                = (state_q == IDLE) && !int_req;
    assign busy                    = (state_q != IDLE);
    assign memory_read             = out_q.rd;
    assign memory_write            = out_q.wr;
    assign memory_push             = out_q.push;
    assign memory_pop              = out_q.pop;
    assign memory_address_select   = out_q.addr;
    assign memory_write_src_select = out_q.src;
    assign pc_choose_memory        = out_q.pcm;
    assign interrupt               = out_q.intr;
    assign restore_flags           = out_q.rflg;
    assign int_ack                 = out_q.ack;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: directed scenarios then random traffic, every cycle
// compared with a model that expands each accepted op into its list of output words.
module tb_mem_sequencer;

    logic       clk = 1'b0;
    logic       reset, op_valid, int_req;
    logic [2:0] op_code;
    logic       op_ready, busy;
    logic       memory_read, memory_write, memory_push, memory_pop;
    logic [1:0] memory_address_select, memory_write_src_select;
    logic       pc_choose_memory, interrupt, restore_flags, int_ack;

    int errors = 0;
    int checks = 0;

    // Remaining expected output words of the running sequence; empty means IDLE.
    logic [11:0] seq_q[$];

    mem_sequencer dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .int_req(int_req), .op_ready(op_ready), .busy(busy),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_push(memory_push), .memory_pop(memory_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .pc_choose_memory(pc_choose_memory), .interrupt(interrupt),
        .restore_flags(restore_flags), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    // Output word layout: rd wr push pop addr[2] src[2] pcm intr rflg ack
    function automatic logic [11:0] w(input logic rd, input logic wr, input logic pu,
                                      input logic po, input logic [1:0] a, input logic [1:0] s,
                                      input logic pcm, input logic it, input logic rf,
                                      input logic ak);
        return {rd, wr, pu, po, a, s, pcm, it, rf, ak};
    endfunction

    function automatic logic [11:0] pop_sp();
        return w(1, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    endfunction

    function automatic logic [11:0] push_sp(input logic [1:0] s);
        return w(0, 1, 1, 0, 2'b10, s, 0, 0, 0, 0);
    endfunction

    task automatic model_start(input logic irq, input logic v, input logic [2:0] op);
        if (irq) begin
            seq_q.push_back(push_sp(2'b01));
            seq_q.push_back(push_sp(2'b10));
            seq_q.push_back(push_sp(2'b00));
            seq_q.push_back(w(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1));
        end else if (v) begin
            case (op)
                3'd1: seq_q.push_back(w(1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0));
                3'd2: seq_q.push_back(w(0, 1, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0));
                3'd3: seq_q.push_back(push_sp(2'b11));
                3'd4: seq_q.push_back(pop_sp());
                3'd5: begin
                    seq_q.push_back(push_sp(2'b01));
                    seq_q.push_back(push_sp(2'b10));
                end
                3'd6, 3'd7: begin
                    if (op == 3'd7) seq_q.push_back(pop_sp() | w(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0));
                    seq_q.push_back(pop_sp());
                    seq_q.push_back(pop_sp());
                    seq_q.push_back(w(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0));
                end
                default: ;
            endcase
        end
    endtask

    // Apply inputs for one cycle, optionally check, then advance the model at the edge.
    task automatic step(input logic rst, input logic v, input logic [2:0] op,
                        input logic irq, input bit chk);
        logic [11:0] exp_w, obs_w;
        logic        exp_rdy, exp_busy;
        @(negedge clk);
        reset = rst; op_valid = v; op_code = op; int_req = irq;
        #1;
        if (chk) begin
            exp_w    = (seq_q.size() != 0) ? seq_q[0] : 12'h000;
            exp_busy = (seq_q.size() != 0);
            exp_rdy  = (seq_q.size() == 0) && !irq;
            obs_w    = {memory_read, memory_write, memory_push, memory_pop,
                        memory_address_select, memory_write_src_select,
                        pc_choose_memory, interrupt, restore_flags, int_ack};
            checks++;
            assert (obs_w === exp_w) else begin
                errors++;
                $error("FAIL outputs t=%0t obs=%h exp=%h", $time, obs_w, exp_w);
            end
            checks++;
            assert (busy === exp_busy) else begin
                errors++;
                $error("FAIL busy t=%0t obs=%b exp=%b", $time, busy, exp_busy);
            end
            checks++;
            assert (op_ready === exp_rdy) else begin
                errors++;
                $error("FAIL op_ready t=%0t obs=%b exp=%b", $time, op_ready, exp_rdy);
            end
        end
        @(posedge clk);
        if (rst) seq_q.delete();
        else if (seq_q.size() != 0) void'(seq_q.pop_front());
        else model_start(irq, v, op);
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; int_req = 1'b0;
        step(1, 0, 3'd0, 0, 0);
        step(1, 0, 3'd0, 0, 0);
        // LDD for one cycle, then idle
        step(0, 1, 3'd1, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        // NOP stays idle
        step(0, 1, 3'd0, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        // CALL
        step(0, 1, 3'd5, 0, 1);
        repeat (3) step(0, 0, 3'd0, 0, 1);
        // RTI
        step(0, 1, 3'd7, 0, 1);
        repeat (5) step(0, 0, 3'd0, 0, 1);
        // Interrupt and STD offered together; STD held until accepted
        step(0, 1, 3'd2, 1, 1);
        repeat (4) step(0, 1, 3'd2, 0, 1);
        step(0, 1, 3'd2, 0, 1);
        repeat (2) step(0, 0, 3'd0, 0, 1);
        // Interrupt raised during CALL_LO is deferred
        step(0, 1, 3'd5, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        step(0, 0, 3'd0, 1, 1);
        step(0, 0, 3'd0, 1, 1);
        step(0, 0, 3'd0, 0, 1);
        repeat (4) step(0, 0, 3'd0, 0, 1);
        // PUSH, POP, STD back to back
        step(0, 1, 3'd3, 0, 1);
        step(0, 1, 3'd4, 0, 1);
        step(0, 1, 3'd4, 0, 1);
        step(0, 1, 3'd2, 0, 1);
        step(0, 1, 3'd2, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        // RET aborted by reset during RET_HI
        step(0, 1, 3'd6, 0, 1);
        step(0, 0, 3'd0, 0, 1);
        step(1, 0, 3'd0, 0, 1);
        repeat (3) step(0, 0, 3'd0, 0, 1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 The block SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have ports: op_valid  input  1  memory operation offered by execute stage.
REQ-004 The block SHALL have ports: op_code  input  3  000 NOP, 001 LDD, 010 STD, 011 PUSH, 100 POP, 101 CALL, 110 RET, 111 RTI.
REQ-005 The block SHALL have ports: int_req  input  1  level interrupt request.
REQ-006 The block SHALL have ports: op_ready  output  1  op accepted on this edge when op_valid and op_ready are both 1.
REQ-007 The block SHALL have ports: busy  output  1  sequence in progress; upstream stages hold.
REQ-008 The block SHALL have ports: memory_read, memory_write, memory_push, memory_pop  output  1 each  memory-stage strobes.
REQ-009 The block SHALL have ports: memory_address_select  output  2  00 std_address, 01 ldd_address, 10 sp.
REQ-010 The block SHALL have ports: memory_write_src_select  output  2  00 flags, 01 pc[31:16], 10 pc[15:0], 11 register data.
REQ-011 The block SHALL have ports: pc_choose_memory, interrupt, restore_flags, int_ack  output  1 each  PC source from shift register, force PC to 0, load flags from read data, interrupt taken.
REQ-012 Reset SHALL be reset, synchronous, active-high; clock SHALL be clk; no parameters.

Function
REQ-013 States SHALL be IDLE, ONE, CALL_HI, CALL_LO, RET_LO, RET_HI, RTI_FLG, RTI_LO, RTI_HI, LOAD_PC, INT_HI, INT_LO, INT_FLG, INT_JMP.
REQ-014 All strobe and select outputs SHALL be registered and driven purely by state; defaults are strobes 0 and selects 00.
REQ-015 op_ready SHALL equal (state==IDLE && !int_req); busy SHALL equal (state!=IDLE).
REQ-016 In IDLE, int_req SHALL take priority over op_valid; the next state is INT_HI and the offered op is not accepted.
REQ-017 On acceptance, NOP SHALL keep IDLE; LDD/STD/PUSH/POP SHALL go to ONE for exactly one cycle, with the accepted op_code latched.
REQ-018 In ONE: LDD SHALL assert read with addr 01; STD SHALL assert write with addr 00 and src 11; PUSH SHALL assert push and write with addr 10 and src 11; POP SHALL assert pop and read with addr 10.
REQ-019 CALL SHALL sequence CALL_HI (push, write, addr 10, src 01) -> CALL_LO (push, write, addr 10, src 10) -> IDLE.
REQ-020 RET SHALL sequence RET_LO (pop, read, addr 10) -> RET_HI (pop, read, addr 10) -> LOAD_PC (pc_choose_memory=1) -> IDLE.
REQ-021 RTI SHALL sequence RTI_FLG (pop, read, addr 10, restore_flags=1) -> RTI_LO -> RTI_HI -> LOAD_PC -> IDLE, with RTI_LO and RTI_HI as in RET.
REQ-022 Interrupt SHALL sequence INT_HI (src 01) -> INT_LO (src 10) -> INT_FLG (src 00), each with push, write, addr 10, then INT_JMP (interrupt=1, int_ack=1) -> IDLE.
REQ-023 int_req arriving while busy SHALL be deferred and serviced from IDLE; there SHALL be no nesting and no aborting of a sequence.
REQ-024 Accepted-op latency SHALL be: first strobe on the cycle after acceptance; total busy cycles are NOP 0, single 1, CALL 2, RET 3, RTI 4, interrupt 4.
REQ-025 Back-to-back ops SHALL be accepted on the edge that returns the FSM to IDLE only if op_ready is 1 on that edge, so at least one IDLE cycle separates sequences.
REQ-026 Undefined state encodings SHALL recover to IDLE on the next edge with all outputs at default.

Reset
REQ-027 On any edge with reset=1, the FSM SHALL enter IDLE and all outputs SHALL be 0 on the following cycle, including mid-sequence; a partial sequence is abandoned and not resumed.
REQ-028 After reset, op_ready SHALL be 1 when int_req=0.

Verification
REQ-029 Reset, then LDD offered for 1 cycle -> next cycle read=1, addr=01, others 0; busy=1 for exactly 1 cycle.
REQ-030 CALL accepted -> cycle+1 push/write src=01 addr=10; cycle+2 src=10; cycle+3 IDLE with op_ready=1.
REQ-031 RTI accepted -> RTI_FLG with restore_flags=1, then two pop/read cycles, then pc_choose_memory=1 for 1 cycle; total busy=4.
REQ-032 int_req=1 and op_valid=1 (STD) in the same IDLE cycle -> op_ready=0; writes src 01, 10, 00, then interrupt=int_ack=1; STD accepted the cycle after return to IDLE.
REQ-033 int_req raised during CALL_LO -> CALL completes, then one IDLE cycle, then INT_HI.
REQ-034 reset asserted during RET_HI -> next cycle all outputs 0, state IDLE, pc_choose_memory never asserted.
